mem_arbiter: RTL
================

# mem_arbiter

Sequencing controller that shares one multi-cycle `mem_system` instance between the instruction-fetch port (stage 1) and the data-memory port (stage 4). It grants one requester at a time, issues the access, waits for `Done`, and steers the result back. It also squashes fetches on redirect, prevents fetch starvation, and flags hung or erroring transactions.

## Interface
- `TIMEOUT`, 8'd200: max cycles in a WAIT state before `err`; legal 1..255.

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, level, held until `if_done`
- `if_addr`  in  16  fetch address, stable while `if_req`
- `flush`  in  1  fetch redirect: squash in-flight/pending fetch
- `if_data`  out  16  fetched instruction, valid with `if_done`
- `if_done`  out  1  fetch complete, 1-cycle pulse
- `if_stall`  out  1  `if_req & ~if_done`
- `dm_req`  in  1  data request, level, held until `dm_done`
- `dm_wr`  in  1  1 = write, 0 = read
- `dm_addr`  in  16  data address
- `dm_wdata`  in  16  write data
- `dm_rdata`  out  16  read data, valid with `dm_done`
- `dm_done`  out  1  data access complete, 1-cycle pulse
- `dm_stall`  out  1  `dm_req & ~dm_done`
- `halt`  in  1  block new grants; in-flight access completes
- `mem_rd`, `mem_wr`  out  1  command to `mem_system`, 1-cycle
- `mem_addr`, `mem_din`  out  16  latched address / write data
- `mem_dout`  in  16  `mem_system` DataOut
- `mem_done`, `mem_stall`, `mem_err`  in  1  `mem_system` status
- `idle`  out  1  state == IDLE
- `err`  out  1  sticky error

## Operation
- States: IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT. Internal regs: `addr_q`, `din_q`, `wr_q`, `last_d` (last grant was data), `squash`, 8-bit `tcnt`.
- IDLE grant, evaluated only when `~halt`:
  - Both requesting, `~last_d` -> data.
  - Both requesting, `last_d` -> fetch.
  - Only one requesting -> that one.
  - Fetch is not granted in a cycle with `flush`=1.
  - On grant: latch addr/wdata/wr, set `last_d`, go to I_REQ or D_REQ.
- I_REQ drives `mem_rd`=1. D_REQ drives `mem_wr`=`wr_q` and `mem_rd`=`~wr_q`. `mem_addr`/`mem_din` = latched values in every non-IDLE state; 0 in IDLE.
- REQ state with `mem_done` -> complete same cycle, go to IDLE. Otherwise -> WAIT.
- WAIT: hold until `mem_done`, then complete and go to IDLE. `mem_stall` is informational only.
- Completion outputs, combinational in the `mem_done` cycle:
  - `if_done = mem_done & fetch-state & ~squash & ~flush`; `if_data = mem_dout`.
  - `dm_done = mem_done & data-state`; `dm_rdata = mem_dout`. A write also pulses `dm_done`.
  - `if_data`/`dm_rdata` = 0 when not done.
- `flush` in I_REQ/I_WAIT sets `squash`. `squash` is cleared on entering IDLE. A squashed fetch still waits for `mem_done` and produces no `if_done`.
- `tcnt` clears on every grant and increments each WAIT cycle. `tcnt == TIMEOUT` -> `err`=1 and state goes to IDLE, with no done pulse.
- `mem_err`=1 in any non-IDLE state -> `err`=1; the transaction continues normally.
- `err` clears only on reset.

## Timing
- Reset (asynchronous, `rst`=0) forces, immediately:
  - state IDLE, all outputs 0, `err`=0;
  - `last_d`=0, `squash`=0, `tcnt`=0.
- Any in-flight access is abandoned.
- Minimum latency, request to done: 2 cycles (grant cycle in IDLE, then `mem_done` in REQ).
- Back-to-back accesses: one IDLE cycle separates transactions. The requester updates or drops `req` on its done cycle; a held `req` in the next IDLE is a new request.
- `halt` asserted mid-transaction: the access completes, then the block stays in IDLE.

## Test plan
- Reset then fetch `if_addr`=16'h0000; `mem_done` in I_REQ -> `mem_rd` one cycle, `mem_addr`=16'h0000, `if_done` pulses with `if_data`=`mem_dout`=16'hC0DE.
- `if_req` and `dm_req`(rd, 16'h0040) both rise from reset -> data granted first (`dm_done`, `dm_rdata`=16'h1234 after 3-cycle miss), fetch granted next IDLE cycle.
- Both held continuously for 4 transactions -> grants alternate D, I, D, I; neither `*_stall` exceeds 2 transactions.
- `flush` in I_WAIT cycle 2, `mem_done` at cycle 4 -> no `if_done`, `if_stall` stays 1; the new address is fetched in the next grant.
- Write `dm_addr`=16'h0010, `dm_wdata`=16'hBEEF -> `mem_wr`=1, `mem_rd`=0, `mem_din`=16'hBEEF, `dm_done` on `mem_done`.
- `TIMEOUT`=5, no `mem_done` -> `err`=1 after 5 WAIT cycles, block returns to IDLE.
- Separately, `rst`=0 mid-D_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and mem_system command/status signals
// shared by the arbiter (slave) and its environment (master).
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        flush;
  logic [15:0] if_data;
  logic        if_done;
  logic        if_stall;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        halt;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_done;
  logic        mem_stall;
  logic        mem_err;
  logic        idle;
  logic        err;

  modport slave (
    input  if_req, if_addr, flush, dm_req, dm_wr, dm_addr, dm_wdata, halt,
           mem_dout, mem_done, mem_stall, mem_err,
    output if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_rd, mem_wr, mem_addr, mem_din, idle, err
  );

  modport master (
    output if_req, if_addr, flush, dm_req, dm_wr, dm_addr, dm_wdata, halt,
           mem_dout, mem_done, mem_stall, mem_err,
    input  if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_rd, mem_wr, mem_addr, mem_din, idle, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle mem_system between instruction fetch and data memory:
// round-robin grant, single-cycle command, wait for done, steer result back.
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        wr_q, wr_d;
  logic        last_d_q, last_d_d;
  logic        squash_q, squash_d;
  logic        err_q, err_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic fetch_st, data_st, busy, done;
  logic i_ok, gnt_d, gnt_i;
  logic unused_stall;

  assign fetch_st = (state_q == I_REQ) || (state_q == I_WAIT);
  assign data_st  = (state_q == D_REQ) || (state_q == D_WAIT);
  assign busy     = fetch_st | data_st;
  assign done     = busy & bus.mem_done;

  // A fetch is never granted in a redirect cycle; ties go to whoever lost last.
  assign i_ok  = bus.if_req & ~bus.flush;
  assign gnt_d = ~bus.halt & bus.dm_req & (~i_ok | ~last_d_q);
  assign gnt_i = ~bus.halt & i_ok & (~bus.dm_req | last_d_q);

  // mem_stall carries no control meaning here.
  assign unused_stall = bus.mem_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      last_d_q <= 1'b0;
      squash_q <= 1'b0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wr_q     <= wr_d;
      last_d_q <= last_d_d;
      squash_q <= squash_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wr_d     = wr_q;
    last_d_d = last_d_q;
    squash_d = squash_q;
    err_d    = err_q;
    tcnt_d   = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d  = D_REQ;
          addr_d   = bus.dm_addr;
          din_d    = bus.dm_wdata;
          wr_d     = bus.dm_wr;
          last_d_d = 1'b1;
          tcnt_d   = '0;
        end else if (gnt_i) begin
          state_d  = I_REQ;
          addr_d   = bus.if_addr;
          din_d    = '0;
          wr_d     = 1'b0;
          last_d_d = 1'b0;
          tcnt_d   = '0;
        end
      end
      I_REQ:  state_d = bus.mem_done ? IDLE : I_WAIT;
      D_REQ:  state_d = bus.mem_done ? IDLE : D_WAIT;
      I_WAIT, D_WAIT: begin
        // A done arriving in the timeout cycle still completes normally.
        if (bus.mem_done) begin
          state_d = IDLE;
        end else if (tcnt_q == TIMEOUT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d  = tcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (busy && bus.mem_err) err_d = 1'b1;
    if (state_d == IDLE)            squash_d = 1'b0;
    else if (fetch_st && bus.flush) squash_d = 1'b1;
  end

  assign bus.mem_rd   = (state_q == I_REQ) | ((state_q == D_REQ) & ~wr_q);
  assign bus.mem_wr   = (state_q == D_REQ) & wr_q;
  assign bus.mem_addr = busy ? addr_q : 16'h0000;
  assign bus.mem_din  = busy ? din_q  : 16'h0000;

  assign bus.if_done  = done & fetch_st & ~squash_q & ~bus.flush;
  assign bus.if_data  = bus.if_done ? bus.mem_dout : 16'h0000;
  assign bus.dm_done  = done & data_st;
  assign bus.dm_rdata = bus.dm_done ? bus.mem_dout : 16'h0000;

  // Stall and idle are qualified by reset so every output reads 0 while held.
  assign bus.if_stall = rst & bus.if_req & ~bus.if_done;
  assign bus.dm_stall = rst & bus.dm_req & ~bus.dm_done;
  assign bus.idle     = rst & (state_q == IDLE);
  assign bus.err      = err_q;

endmodule
